// File: rtl/pixel_imagenes_if.sv
// Pixel-stream bundle between the image-position stage, the image ROM and the video output.
// The slave side is the pixel_imagenes block; the master side drives pixels and the ROM row.
interface pixel_imagenes_if;
    logic [8:0]  DIR_IM;
    logic [4:0]  px_col;
    logic        video_on;
    logic        hsync_in;
    logic        vsync_in;
    logic [11:0] rgb_fondo;
    logic        blink_en;
    logic [8:0]  rom_addr;
    logic [31:0] rom_data;
    logic [11:0] rgb;
    logic        hsync_out;
    logic        vsync_out;

    modport slave (
        input  DIR_IM, px_col, video_on, hsync_in, vsync_in, rgb_fondo, blink_en, rom_data,
        output rom_addr, rgb, hsync_out, vsync_out
    );

    modport master (
        output DIR_IM, px_col, video_on, hsync_in, vsync_in, rgb_fondo, blink_en, rom_data,
        input  rom_addr, rgb, hsync_out, vsync_out
    );
endinterface

// File: rtl/pixel_imagenes.sv
// Serialises 32x32 1-bpp image rows into palette pixels over the text-layer background.
// Latency 3 cycles for rgb and syncs; no backpressure, one pixel accepted every clock.
module pixel_imagenes #(
    parameter logic [11:0] COL_CAL      = 12'hF80,
    parameter logic [11:0] COL_CRONO    = 12'h0F8,
    parameter logic [11:0] COL_HORA     = 12'h8F0,
    parameter logic [11:0] COL_AVATAR   = 12'hFF0,
    parameter logic [11:0] COL_AMPM     = 12'hFFF,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic             reloj,
    input  logic             resetM,
    pixel_imagenes_if.slave  px
);

    typedef enum logic {VISIBLE = 1'b0, HIDDEN = 1'b1} blink_state_t;

    localparam logic [7:0] CNT_LAST = 8'(BLINK_FRAMES - 1);

    logic [3:0]   idx_d1;
    logic [4:0]   col_d1, col_d2;
    logic         von_d1, von_d2;
    logic [11:0]  fondo_d1, fondo_d2;
    logic         hs_d1, hs_d2, vs_d1, vs_d2;
    logic         ben_d1, ben_d2;
    logic         vs_prev;
    logic [7:0]   cnt_q, cnt_d;
    blink_state_t state_q, state_d;

    logic         frame_tick;
    logic [4:0]   bit_sel;
    logic         pix_bit;
    logic         ampm;
    logic         opaque;
    logic [11:0]  palette;
    logic [11:0]  rgb_d;

    assign px.rom_addr = px.DIR_IM;

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            idx_d1       <= '0;
            col_d1       <= '0;
            col_d2       <= '0;
            von_d1       <= 1'b0;
            von_d2       <= 1'b0;
            fondo_d1     <= '0;
            fondo_d2     <= '0;
            hs_d1        <= 1'b1;
            hs_d2        <= 1'b1;
            vs_d1        <= 1'b1;
            vs_d2        <= 1'b1;
            ben_d1       <= 1'b0;
            ben_d2       <= 1'b0;
            px.rgb       <= '0;
            px.hsync_out <= 1'b1;
            px.vsync_out <= 1'b1;
        end else begin
            idx_d1       <= px.DIR_IM[8:5];
            col_d1       <= px.px_col;
            col_d2       <= col_d1;
            von_d1       <= px.video_on;
            von_d2       <= von_d1;
            fondo_d1     <= px.rgb_fondo;
            fondo_d2     <= fondo_d1;
            hs_d1        <= px.hsync_in;
            hs_d2        <= hs_d1;
            vs_d1        <= px.vsync_in;
            vs_d2        <= vs_d1;
            ben_d1       <= px.blink_en;
            ben_d2       <= ben_d1;
            px.rgb       <= rgb_d;
            px.hsync_out <= hs_d2;
            px.vsync_out <= vs_d2;
        end
    end

    // Column 0 is the leftmost pixel, held in bit 31 of the ROM row.
    assign bit_sel = ~col_d2;
    assign pix_bit = px.rom_data[bit_sel];
    assign ampm    = (idx_d1 == 4'd5) || (idx_d1 == 4'd6);

    always_comb begin
        palette = '0;
        case (idx_d1)
            4'd1:       palette = COL_CAL;
            4'd2:       palette = COL_CRONO;
            4'd3:       palette = COL_HORA;
            4'd4:       palette = COL_AVATAR;
            4'd5, 4'd6: palette = COL_AMPM;
            default:    palette = '0;
        endcase
    end

    always_comb begin
        opaque = (idx_d1 >= 4'd1) && (idx_d1 <= 4'd6) && pix_bit
                 && !(ampm && ben_d2 && (state_q == HIDDEN));
        rgb_d  = '0;
        if (!von_d2)
            rgb_d = '0;
        else if (opaque)
            rgb_d = palette;
        else
            rgb_d = fondo_d2;
    end

    // Frame tick: falling edge of vsync seen against its own previous sample.
    assign frame_tick = vs_prev && !px.vsync_in;

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            vs_prev <= 1'b1;
            cnt_q   <= '0;
            state_q <= VISIBLE;
        end else begin
            vs_prev <= px.vsync_in;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (!px.blink_en) begin
            cnt_d   = '0;
            state_d = VISIBLE;
        end else if (frame_tick) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                state_d = (state_q == VISIBLE) ? HIDDEN : VISIBLE;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_imagenes.sv
// Directed bench for pixel_imagenes: latency, bit order, palette, blanking, blink and sync alignment.
module tb_pixel_imagenes;

    localparam logic [11:0] C_CAL    = 12'hF80;
    localparam logic [11:0] C_CRONO  = 12'h0F8;
    localparam logic [11:0] C_HORA   = 12'h8F0;
    localparam logic [11:0] C_AVATAR = 12'hFF0;
    localparam logic [11:0] C_AMPM   = 12'hFFF;

    logic reloj  = 1'b0;
    logic resetM = 1'b0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    always #5 reloj = ~reloj;

    pixel_imagenes_if vif ();

    pixel_imagenes #(.BLINK_FRAMES(2)) dut (
        .reloj  (reloj),
        .resetM (resetM),
        .px     (vif)
    );

    task automatic step();
        @(posedge reloj);
        #1;
    endtask

    task automatic apply(input logic [8:0] dir, input logic [4:0] col, input logic von,
                         input logic [11:0] fondo, input logic [31:0] rom);
        vif.DIR_IM    = dir;
        vif.px_col    = col;
        vif.video_on  = von;
        vif.rgb_fondo = fondo;
        vif.rom_data  = rom;
    endtask

    task automatic vs_pulse();
        vif.vsync_in = 1'b0;
        step();
        vif.vsync_in = 1'b1;
        step();
    endtask

    task automatic test_reset();
        resetM = 1'b0;
        apply(9'h1A5, 5'd7, 1'b1, 12'hABC, 32'hFFFF_FFFF);
        vif.hsync_in = 1'b0;
        vif.vsync_in = 1'b0;
        vif.blink_en = 1'b0;
        repeat (5) step();
        n_cmp++;
        if (vif.rgb !== 12'h000) begin
            n_err++; $display("FAIL reset_rgb got %h want %h", vif.rgb, 12'h000);
        end
        n_cmp++;
        if (vif.hsync_out !== 1'b1 || vif.vsync_out !== 1'b1) begin
            n_err++; $display("FAIL reset_sync got %b%b want 11", vif.hsync_out, vif.vsync_out);
        end
        n_cmp++;
        if (vif.rom_addr !== 9'h1A5) begin
            n_err++; $display("FAIL reset_rom_addr got %h want %h", vif.rom_addr, 9'h1A5);
        end
        resetM = 1'b1;
        vif.hsync_in = 1'b1;
        vif.vsync_in = 1'b1;
        apply(9'h060, 5'd0, 1'b1, 12'h00F, 32'h8000_0001);
        step();
        step();
        n_cmp++;
        if (vif.rgb !== 12'h000) begin
            n_err++; $display("FAIL release_early got %h want %h", vif.rgb, 12'h000);
        end
        step();
        n_cmp++;
        if (vif.rgb !== C_HORA) begin
            n_err++; $display("FAIL release_first got %h want %h", vif.rgb, C_HORA);
        end
    endtask

    task automatic test_bit_order();
        logic [11:0] exp;
        for (int i = 0; i < 34; i++) begin
            if (i < 32) apply(9'h060, 5'(i), 1'b1, 12'h00F, 32'h8000_0001);
            step();
            if (i >= 2) begin
                exp = ((i - 2) == 0 || (i - 2) == 31) ? C_HORA : 12'h00F;
                n_cmp++;
                if (vif.rgb !== exp) begin
                    n_err++; $display("FAIL bit_order col %0d got %h want %h", i - 2, vif.rgb, exp);
                end
            end
        end
    endtask

    task automatic test_transparency();
        logic [8:0]  t_dir [11] = '{9'h000, 9'h0E0, 9'h060, 9'h020, 9'h040, 9'h080,
                                    9'h0A0, 9'h0C0, 9'h065, 9'h060, 9'h1E0};
        logic [31:0] t_rom [11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                    32'hFBFF_FFFF, 32'h0400_0000, 32'hFFFF_FFFF};
        logic        t_von [11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [11:0] t_exp [11] = '{12'h123, 12'h123, 12'h000, C_CAL, C_CRONO, C_AVATAR,
                                    C_AMPM, C_AMPM, 12'h123, C_HORA, 12'h123};
        vif.blink_en = 1'b0;
        for (int k = 0; k < 11; k++) begin
            apply(t_dir[k], 5'd5, t_von[k], 12'h123, t_rom[k]);
            repeat (3) step();
            n_cmp++;
            if (vif.rgb !== t_exp[k]) begin
                n_err++; $display("FAIL transparency vec %0d got %h want %h", k, vif.rgb, t_exp[k]);
            end
        end
    endtask

    task automatic test_blink();
        logic [11:0] exp;
        vif.blink_en = 1'b1;
        apply(9'h0C0, 5'd9, 1'b1, 12'h0A0, 32'hFFFF_FFFF);
        repeat (3) step();
        for (int f = 0; f < 6; f++) begin
            exp = (f == 2 || f == 3) ? 12'h0A0 : C_AMPM;
            n_cmp++;
            if (vif.rgb !== exp) begin
                n_err++; $display("FAIL blink frame %0d got %h want %h", f, vif.rgb, exp);
            end
            vs_pulse();
            repeat (3) step();
        end
        n_cmp++;
        if (vif.rgb !== 12'h0A0) begin
            n_err++; $display("FAIL blink frame 6 got %h want %h", vif.rgb, 12'h0A0);
        end
        vif.blink_en = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (vif.rgb !== C_AMPM) begin
            n_err++; $display("FAIL blink_release got %h want %h", vif.rgb, C_AMPM);
        end
    endtask

    task automatic test_sync();
        logic hs_h [40];
        logic vs_h [40];
        vif.blink_en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            hs_h[i] = 1'($urandom_range(0, 1));
            vs_h[i] = 1'($urandom_range(0, 1));
            vif.hsync_in = hs_h[i];
            vif.vsync_in = vs_h[i];
            step();
            if (i >= 2) begin
                n_cmp++;
                if (vif.hsync_out !== hs_h[i - 2] || vif.vsync_out !== vs_h[i - 2]) begin
                    n_err++;
                    $display("FAIL sync_align step %0d got %b%b want %b%b", i,
                             vif.hsync_out, vif.vsync_out, hs_h[i - 2], vs_h[i - 2]);
                end
            end
        end
        vif.hsync_in = 1'b1;
        vif.vsync_in = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_reset_midline();
        vif.blink_en = 1'b1;
        apply(9'h060, 5'd0, 1'b1, 12'h00F, 32'h8000_0000);
        vs_pulse();
        repeat (3) step();
        n_cmp++;
        if (vif.rgb !== C_HORA) begin
            n_err++; $display("FAIL midline_pre got %h want %h", vif.rgb, C_HORA);
        end
        vif.hsync_in = 1'b0;
        step();
        #2 resetM = 1'b0;
        #1;
        n_cmp++;
        if (vif.rgb !== 12'h000 || vif.hsync_out !== 1'b1) begin
            n_err++; $display("FAIL midline_async got %h/%b want 000/1", vif.rgb, vif.hsync_out);
        end
        vif.hsync_in = 1'b1;
        step();
        resetM = 1'b1;
        apply(9'h0C0, 5'd0, 1'b1, 12'h00F, 32'hFFFF_FFFF);
        vs_pulse();
        repeat (3) step();
        n_cmp++;
        if (vif.rgb !== C_AMPM) begin
            n_err++; $display("FAIL midline_cnt_cleared got %h want %h", vif.rgb, C_AMPM);
        end
        vs_pulse();
        repeat (3) step();
        n_cmp++;
        if (vif.rgb !== 12'h00F) begin
            n_err++; $display("FAIL midline_second_tick got %h want %h", vif.rgb, 12'h00F);
        end
        vif.blink_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bit_order();
        test_transparency();
        test_blink();
        test_sync();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pixel_imagenes.md
Name: pixel_imagenes

Overview:
- Downstream stage of the image-position block. Takes its 9-bit image ROM address (DIR_IM), drives the 32x32 1-bpp image ROM and serialises the returned 32-bit row into pixels.
- Colours each image pixel from a per-image palette and overlays it on the background RGB from the text layer.
- Aligns HSYNC/VSYNC with the data path.
- Blinks the AM/PM indicator while hour edit is active.

Parameters:
- COL_CAL, 12'hF80, RGB444 colour for image index 1 (calendar)
- COL_CRONO, 12'h0F8, RGB444 colour for index 2 (chronometer)
- COL_HORA, 12'h8F0, RGB444 colour for index 3 (clock)
- COL_AVATAR, 12'hFF0, RGB444 colour for index 4 (avatar)
- COL_AMPM, 12'hFFF, RGB444 colour for indices 5 and 6 (AM/PM)
- BLINK_FRAMES, 30, frames per blink half-period (2..255)

Ports:
- reloj  in  1  pixel clock (25 MHz); every cycle is one pixel
- resetM  in  1  asynchronous reset, active-low
- DIR_IM  in  9  image ROM address: [8:5] image index (0 = none), [4:0] row within tile
- px_col  in  5  pixel column within tile (x[4:0]); presented the same cycle as the Qh/Qv that produced DIR_IM
- video_on  in  1  active-area flag, aligned with px_col
- hsync_in  in  1  horizontal sync, active-low, aligned with px_col
- vsync_in  in  1  vertical sync, active-low, aligned with px_col
- rgb_fondo  in  12  background/text RGB444, aligned with px_col
- blink_en  in  1  1 = hour edit active, blink AM/PM
- rom_addr  out  9  synchronous ROM address
- rom_data  in  32  ROM row, valid one cycle after rom_addr; bit 31 = leftmost pixel
- rgb  out  12  final pixel colour, registered
- hsync_out  out  1  hsync_in delayed to match rgb
- vsync_out  out  1  vsync_in delayed to match rgb

Behaviour:
- Reset (resetM=0, asynchronous):
  - all pipeline registers cleared; rgb=0; hsync_out=vsync_out=1.
  - blink counter=0; blink_phase=0.
- Timing, with t = cycle the px_col/sync/rgb_fondo/video_on group is presented:
  - t+1: DIR_IM valid (upstream registers one cycle). rom_addr = DIR_IM, combinational passthrough.
  - t+2: rom_data valid. The block holds idx = DIR_IM[8:5] registered once, and px_col, video_on, rgb_fondo and the syncs registered twice.
  - Edge ending t+2 loads rgb, hsync_out and vsync_out. Total latency is exactly 3 cycles for rgb and both syncs.
- Pixel select: bit = rom_data[31 - col_d2], where col_d2 is the 5-bit column delayed 2 cycles. col_d2=0 selects bit 31; col_d2=31 selects bit 0.
- Transparency: the pixel is transparent if any of these holds:
  - idx = 0 or idx > 6;
  - bit = 0;
  - idx in {5,6} and blink_en_d2=1 and blink_phase=1.
- Colour:
  - video_on_d2=0: rgb=0.
  - Opaque pixel: rgb = palette[idx].
  - Otherwise: rgb = rgb_fondo_d2.
- Blink FSM, two states, VISIBLE (blink_phase=0) and HIDDEN (blink_phase=1):
  - Frame tick = falling edge of vsync_in, detected against its own 1-cycle-delayed copy; one tick per frame.
  - On a tick with blink_en=1: the 8-bit counter increments. When it reaches BLINK_FRAMES-1, the counter wraps to 0 and the phase toggles on that tick.
  - blink_en=0: counter and phase forced to 0 synchronously, so AM/PM shows immediately when editing ends.
  - Phase changes only on frame ticks while blink_en=1, so there is no mid-frame tearing from the counter.
  - A blink_en edge mid-frame takes effect on pixels from then on (through the 2-cycle delay).
- Reset mid-frame: outputs go to reset values at once. After release, output follows inputs with the 3-cycle latency; no resynchronisation is needed.
- Widths: all selection is by index, no arithmetic except the 8-bit blink counter; 31 - col is a 5-bit bitwise inversion of col.

Test Plan:
- Reset: hold resetM=0 for 5 cycles with arbitrary inputs -> rgb=0, hsync_out=vsync_out=1, rom_addr follows DIR_IM; release -> first valid rgb 3 cycles after input.
- Bit order and latency: DIR_IM=9'h060 (idx 3, row 0), rom_data=32'h8000_0001, px_col sweeping 0..31, video_on=1, rgb_fondo=12'h00F -> rgb=COL_HORA at col 0 and col 31, 12'h00F elsewhere; each value appears 3 cycles after its px_col.
- Transparency and blanking:
  - idx 0 with rom_data=32'hFFFF_FFFF -> rgb=rgb_fondo.
  - idx 7 -> rgb=rgb_fondo.
  - video_on=0 with an opaque pixel -> rgb=0.
- Blink: BLINK_FRAMES=2, blink_en=1, idx 6, all-ones ROM row, 6 vsync pulses -> AM/PM colour shown frames 0-1, background frames 2-3, colour frames 4-5. Drop blink_en while HIDDEN -> colour within 3 cycles.
- Sync alignment: random hsync_in/vsync_in pattern -> hsync_out/vsync_out equal the inputs delayed exactly 3 cycles, bit-exact.
- Async reset mid-line while an opaque pixel is in flight -> rgb=0 immediately, without waiting for a clock edge; blink counter returns to 0.
